sync_fifo: RTL and testbench

Single-clock, parametrised FIFO buffer with exact occupancy count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It is the single-clock-domain successor to our dual-clock FIFO. It sits between a producer and a consumer in the same clock domain as the general-purpose rate-smoothing buffer. It uses all DEPTH entries; no slot is sacrificed to distinguish full from empty.

---
 rtl/sync_fifo.sv | 100 ++++++++++
 tb/tb_sync_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO using all DEPTH slots, with exact occupancy, almost flags,
// standard or first-word-fall-through read mode, and sticky error flags.
module sync_fifo #(
  parameter int DEPTH    = 8,
  parameter int DWIDTH   = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [DWIDTH-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count_q;
  logic              wr_acc;
  logic              rd_acc;

  // Flags decode the registered count only, never the same-cycle requests.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;

  // A write into a full FIFO is allowed when the same edge frees a slot.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;
      if (rd_en && empty)          underflow <= 1'b1;
      else if (err_clr)            underflow <= 1'b0;
    end
  end

  // Storage is not reset; stale slots are unreachable because rptr never
  // passes wptr.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wptr] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = empty ? '0 : mem[rptr];
    end else begin : g_std
      logic [DWIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rptr];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus and are
// checked against a queue reference plus a table of hand-computed vectors.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0, ov0, uf0;
  logic          full1, empty1, af1, ae1, ov1, uf1;
  logic [CW-1:0] count0, count1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] dout0_m;
  logic          ov_m, uf_m;

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(DEPTH), .DWIDTH(DW), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ov0), .underflow(uf0));

  sync_fifo #(.DEPTH(DEPTH), .DWIDTH(DW), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ov1), .underflow(uf1));

  typedef struct {
    logic          wr, rd, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic          ae, af, full, ov;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count_std",  64'(count0), 64'(n));
    chk("count_fwft", 64'(count1), 64'(n));
    chk("empty_std",  64'(empty0), 64'(n == 0));
    chk("empty_fwft", 64'(empty1), 64'(n == 0));
    chk("full_std",   64'(full0),  64'(n == DEPTH));
    chk("full_fwft",  64'(full1),  64'(n == DEPTH));
    chk("af_std",     64'(af0),    64'(n >= 6));
    chk("af_fwft",    64'(af1),    64'(n >= 6));
    chk("ae_std",     64'(ae0),    64'(n <= 1));
    chk("ae_fwft",    64'(ae1),    64'(n <= 1));
    chk("ovf_std",    64'(ov0),    64'(ov_m));
    chk("ovf_fwft",   64'(ov1),    64'(ov_m));
    chk("udf_std",    64'(uf0),    64'(uf_m));
    chk("udf_fwft",   64'(uf1),    64'(uf_m));
    chk("dout_std",   64'(dout0),  64'(dout0_m));
    chk("dout_fwft",  64'(dout1),  (n == 0) ? 64'd0 : 64'(q[0]));
  endtask

  // Drive at negedge, update the reference at the posedge, sample 1 time unit later.
  task automatic step(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] d);
    logic is_full, is_empty;
    @(negedge clk);
    wr_en = wr; rd_en = rd; err_clr = clr; din = d;
    @(posedge clk);
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
    if (wr && is_full && !rd) ov_m = 1'b1;
    else if (clr)             ov_m = 1'b0;
    if (rd && is_empty)       uf_m = 1'b1;
    else if (clr)             uf_m = 1'b0;
    if (rd && !is_empty) dout0_m = q.pop_front();
    if (wr && (!is_full || rd)) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    dout0_m = '0;
    ov_m = 1'b0;
    uf_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, din: DW'(32'h11 * (i + 1)), cnt: i + 1,
                  ae: (i + 1 <= 1), af: (i + 1 >= 6), full: (i == 7), ov: 1'b0};
    end
    vecs[8] = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, din: 32'h99, cnt: 8, ae: 1'b0, af: 1'b1, full: 1'b1, ov: 1'b1};
    vecs[9] = '{wr: 1'b0, rd: 1'b0, clr: 1'b1, din: 32'h0,  cnt: 8, ae: 1'b0, af: 1'b1, full: 1'b1, ov: 1'b0};

    model_reset();
    #12;
    check_all();
    chk("rst_empty", 64'(empty0), 64'd1);
    chk("rst_ae",    64'(ae0),    64'd1);
    chk("rst_dout",  64'(dout0),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow attempt, error clear.
    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d_count", i), 64'(count0), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d_ae", i),    64'(ae0),    64'(vecs[i].ae));
      chk($sformatf("vec%0d_af", i),    64'(af0),    64'(vecs[i].af));
      chk($sformatf("vec%0d_full", i),  64'(full0),  64'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i), 64'(empty0), 64'd0);
      chk($sformatf("vec%0d_ovf", i),   64'(ov0),    64'(vecs[i].ov));
    end

    // Drain in order, then one rejected read.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk($sformatf("drain%0d", i), 64'(dout0), 64'(32'h11 * (i + 1)));
    end
    step(1'b0, 1'b1, 1'b0, '0);
    chk("udf_set",   64'(uf0),   64'd1);
    chk("udf_dout",  64'(dout0), 64'h88);
    step(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous read and write while full.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'(32'h21 + i));
    step(1'b1, 1'b1, 1'b0, 32'hAA);
    chk("fullsim_dout",  64'(dout0),  64'h21);
    chk("fullsim_count", 64'(count0), 64'd8);
    chk("fullsim_ovf",   64'(ov0),    64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("fullsim_last", 64'(dout0), 64'hAA);

    // Simultaneous read and write while empty.
    step(1'b1, 1'b1, 1'b0, 32'h5A);
    chk("emptysim_count", 64'(count1), 64'd1);
    chk("emptysim_udf",   64'(uf1),    64'd1);
    chk("emptysim_fwft",  64'(dout1),  64'h5A);
    chk("emptysim_std",   64'(dout0),  64'hAA);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("emptysim_pop_empty", 64'(empty1), 64'd1);
    chk("emptysim_pop_fwft",  64'(dout1),  64'd0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Random interleaving, wraps the pointers several times.
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, DW'(32'hC0 + i));

    // Asynchronous reset mid-burst.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; din = 32'hDEAD;
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("midrst_count", 64'(count0), 64'd0);
    chk("midrst_fwft",  64'(dout1),  64'd0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h77);
    chk("postrst_fwft", 64'(dout1), 64'h77);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("postrst_std",  64'(dout0), 64'h77);
    chk("postrst_empty", 64'(empty0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
